// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the key-expansion slice.
// Provides the S-box as arithmetic (field inverse followed by the affine map).
package aes_pkg;

    localparam int unsigned AES_NUM_ROUNDS = 10;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FIN
    } kexp_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Indices outside 1..10 map to zero so an unused lookup never goes out of range.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        logic [7:0] val;
        val = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) begin
                val = RCON[i];
            end
        end
        return val;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] s;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

endpackage

// File: rtl/sub_word.sv
// AES SubWord: applies the S-box to each byte of a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o[31:24] = sbox(word_i[31:24]);
    assign word_o[23:16] = sbox(word_i[23:16]);
    assign word_o[15:8]  = sbox(word_i[15:8]);
    assign word_o[7:0]   = sbox(word_i[7:0]);

endmodule

// File: rtl/key_expansion.sv
// AES-128 round-key generator emitting rounds 0..NUM_ROUNDS over a valid/ready handshake.
// Optional KEY_EXP_STORE_EN adds a readable table of every emitted round key.
module key_expansion
    import aes_pkg::*;
#(
    parameter int unsigned regSize    = 32,
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*regSize-1:0]  key_in,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [4*regSize-1:0]  round_key,
    output logic [3:0]            round_idx,
    output logic                  busy,
    output logic                  done
`ifdef KEY_EXP_STORE_EN
    ,
    input  logic [3:0]            rd_idx,
    output logic [4*regSize-1:0]  rd_key
`endif
);

    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

    kexp_state_t state_q, state_d;
    aes_block_t  round_key_q, round_key_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic        done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_word, sub_out, t_word;
    logic [31:0] n0, n1, n2, n3;
    aes_block_t  next_key;
    logic        handshake;

    assign w0 = round_key_q[127:96];
    assign w1 = round_key_q[95:64];
    assign w2 = round_key_q[63:32];
    assign w3 = round_key_q[31:0];

    assign rot_word = {w3[23:0], w3[31:24]};

    sub_word u_sub_word (
        .word_i(rot_word),
        .word_o(sub_out)
    );

    assign t_word   = sub_out ^ {rcon_lookup(4'(round_idx_q + 4'd1)), 24'h000000};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    assign handshake = (state_q == EMIT) && rk_ready;

    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    round_key_d = key_in;
                    round_idx_d = 4'd0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (round_idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        round_key_d = next_key;
                        round_idx_d = 4'(round_idx_q + 4'd1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_idx_q <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            done_q      <= done_d;
        end
    end

    assign rk_valid  = (state_q == EMIT);
    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

`ifdef KEY_EXP_STORE_EN
    aes_block_t table_q [0:NUM_ROUNDS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
                table_q[i] <= '0;
            end
        end else if (handshake) begin
            table_q[round_idx_q] <= round_key_q;
        end
    end

    assign rd_key = (rd_idx <= LastIdx) ? table_q[rd_idx] : '0;
`endif

endmodule
